// File: rtl/phase_gen_if.sv
// Phase-generator bus: run controls, load, shift handshake and phase outputs.
//   master : coupling/update logic side (drives en, div, load, shift request)
//   slave  : phase_gen side (drives phase, full_tick, wrap_pulse, osc_out, shift_ack)
// Optional: OSC_CNT_EN adds osc_count[15:0] (oscillation counter).
interface phase_gen_if #(
  parameter int PHASE_W = 4,
  parameter int DIV_W   = 8
) ();
  logic               en;
  logic [DIV_W-1:0]   div;
  logic               load;
  logic [PHASE_W-1:0] ini_phase;
  logic               shift_req;
  logic               shift_dir;
  logic               shift_ack;
  logic [PHASE_W-1:0] phase;
  logic               full_tick;
  logic               wrap_pulse;
  logic               osc_out;
`ifdef OSC_CNT_EN
  logic [15:0]        osc_count;

  modport master (
    output en, div, load, ini_phase, shift_req, shift_dir,
    input  shift_ack, phase, full_tick, wrap_pulse, osc_out, osc_count
  );
  modport slave (
    input  en, div, load, ini_phase, shift_req, shift_dir,
    output shift_ack, phase, full_tick, wrap_pulse, osc_out, osc_count
  );
`else
  modport master (
    output en, div, load, ini_phase, shift_req, shift_dir,
    input  shift_ack, phase, full_tick, wrap_pulse, osc_out
  );
  modport slave (
    input  en, div, load, ini_phase, shift_req, shift_dir,
    output shift_ack, phase, full_tick, wrap_pulse, osc_out
  );
`endif
endinterface

// File: rtl/phase_gen.sv
// phase_gen: phase source for one ONN oscillator.
//   A prescaled free-running counter steps the phase through 2**PHASE_W values
//   per oscillation; a req/ack shift FSM nudges the phase one step forward
//   (+2 on a step) or back (+0 on a step).
// Ports:
//   clk  : system clock, rising edge
//   re   : asynchronous active-high reset
//   bus  : phase_gen_if.slave (en, div, load, ini_phase, shift_req, shift_dir
//          in; shift_ack, phase, full_tick, wrap_pulse, osc_out out)
// Optional: define OSC_CNT_EN to add bus.osc_count, a 16-bit count of wraps
//   (cleared by reset and load, wraps 0xFFFF->0).
module phase_gen #(
  parameter int PHASE_W = 4,
  parameter int DIV_W   = 8
) (
  input  logic         clk,
  input  logic         re,
  phase_gen_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT} state_t;

  state_t             r_state;
  logic               r_dir;
  logic [DIV_W-1:0]   r_pre_cnt;
  logic [PHASE_W-1:0] r_phase;
  logic               r_full;
  logic               r_wrap;
  logic               r_ack;
  logic               r_osc;
`ifdef OSC_CNT_EN
  logic [15:0]        r_osc_cnt;
`endif

  logic               w_step;
  logic               w_apply;
  logic [1:0]         w_inc;
  logic [PHASE_W:0]   w_sum;
  logic               w_wrap;
  logic [PHASE_W-1:0] w_phase_nxt;

  // >= so that lowering div below the running count still yields a step.
  assign w_step  = bus.en && (r_pre_cnt >= bus.div);
  assign w_apply = w_step && (r_state == S_PEND);

  // Per-step increment: normal +1, advance +2, retard +0.
  always_comb begin
    w_inc = 2'd0;
    if (w_step) begin
      if (w_apply) w_inc = r_dir ? 2'd2 : 2'd0;
      else         w_inc = 2'd1;
    end
  end

  // Extra carry bit detects the wrap (including 14->0 and 15->1 on advance).
  assign w_sum       = {1'b0, r_phase} + (PHASE_W+1)'(w_inc);
  assign w_wrap      = w_sum[PHASE_W];
  assign w_phase_nxt = w_sum[PHASE_W-1:0];

  always_ff @(posedge clk or posedge re) begin
    if (re) begin
      r_state   <= S_IDLE;
      r_dir     <= 1'b0;
      r_pre_cnt <= '0;
      r_phase   <= '0;
      r_full    <= 1'b0;
      r_wrap    <= 1'b0;
      r_ack     <= 1'b0;
      r_osc     <= 1'b1;
`ifdef OSC_CNT_EN
      r_osc_cnt <= '0;
`endif
    end else if (bus.load) begin
      // Load restarts the initialisation period and drops any pending shift.
      r_state   <= S_IDLE;
      r_pre_cnt <= '0;
      r_phase   <= bus.ini_phase;
      r_full    <= 1'b0;
      r_wrap    <= 1'b0;
      r_ack     <= 1'b0;
      r_osc     <= ~bus.ini_phase[PHASE_W-1];
`ifdef OSC_CNT_EN
      r_osc_cnt <= '0;
`endif
    end else if (!bus.en) begin
      // Frozen: counter, phase and FSM hold; pulses drop.
      r_wrap <= 1'b0;
      r_ack  <= 1'b0;
    end else begin
      r_pre_cnt <= w_step ? '0 : r_pre_cnt + DIV_W'(1);
      r_phase   <= w_phase_nxt;
      r_osc     <= ~w_phase_nxt[PHASE_W-1];
      r_wrap    <= w_wrap;
      r_ack     <= w_apply;
      if (w_wrap) r_full <= 1'b1;
`ifdef OSC_CNT_EN
      if (w_wrap) r_osc_cnt <= r_osc_cnt + 16'd1;
`endif
      case (r_state)
        S_IDLE: if (bus.shift_req) begin
          r_dir   <= bus.shift_dir;
          r_state <= S_PEND;
        end
        S_PEND: if (w_step) r_state <= S_WAIT;
        // Level request: must drop before another shift is accepted.
        S_WAIT: if (!bus.shift_req) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.phase      = r_phase;
  assign bus.full_tick  = r_full;
  assign bus.wrap_pulse = r_wrap;
  assign bus.shift_ack  = r_ack;
  assign bus.osc_out    = r_osc;
`ifdef OSC_CNT_EN
  assign bus.osc_count  = r_osc_cnt;
`endif

endmodule

// File: tb/tb_phase_gen.sv
module tb_phase_gen;
  logic clk = 1'b0;
  logic re  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  phase_gen_if #(.PHASE_W(4), .DIV_W(8)) bus ();
  phase_gen #(.PHASE_W(4), .DIV_W(8)) dut (.clk(clk), .re(re), .bus(bus));

  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.div = 8'd0; bus.load = 1'b0; bus.ini_phase = 4'd0;
    bus.shift_req = 1'b0; bus.shift_dir = 1'b0;
    re = 1'b1;
    tick(); tick();
    checks++;
    if (bus.phase !== 4'd0 || bus.full_tick !== 1'b0 || bus.wrap_pulse !== 1'b0 ||
        bus.shift_ack !== 1'b0 || bus.osc_out !== 1'b1) begin
      errors++;
      $display("FAIL reset: got ph=%0d ft=%b wp=%b ack=%b osc=%b want 0 0 0 0 1",
               bus.phase, bus.full_tick, bus.wrap_pulse, bus.shift_ack, bus.osc_out);
    end
    re = 1'b0;
  endtask

  // div=0: one step per cycle, single wrap at 15->0.
  task automatic test_count();
    bus.div = 8'd0; bus.en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if (bus.phase !== 4'(i % 16) || bus.wrap_pulse !== (i == 16) ||
          bus.full_tick !== (i >= 16) || bus.osc_out !== ((i % 16) < 8)) begin
        errors++;
        $display("FAIL count[%0d]: got ph=%0d wp=%b ft=%b osc=%b want ph=%0d wp=%b ft=%b osc=%b",
                 i, bus.phase, bus.wrap_pulse, bus.full_tick, bus.osc_out,
                 i % 16, i == 16, i >= 16, (i % 16) < 8);
      end
    end
  endtask

  // div=3: step every 4 clocks; run through a wrap up to phase 9.
  task automatic test_prescale();
    bus.div = 8'd3; bus.load = 1'b1; bus.ini_phase = 4'd0;
    tick();
    bus.load = 1'b0;
    checks++;
    if (bus.phase !== 4'd0 || bus.full_tick !== 1'b0) begin
      errors++;
      $display("FAIL prescale load: got ph=%0d ft=%b want 0 0", bus.phase, bus.full_tick);
    end
    for (int k = 1; k <= 100; k++) begin
      tick();
      checks++;
      if (bus.phase !== 4'((k / 4) % 16) || bus.osc_out !== (((k / 4) % 16) < 8) ||
          bus.wrap_pulse !== (k == 64) || bus.full_tick !== (k >= 64)) begin
        errors++;
        $display("FAIL prescale[%0d]: got ph=%0d osc=%b wp=%b ft=%b want ph=%0d osc=%b wp=%b ft=%b",
                 k, bus.phase, bus.osc_out, bus.wrap_pulse, bus.full_tick,
                 (k / 4) % 16, ((k / 4) % 16) < 8, k == 64, k >= 64);
      end
    end
  endtask

  // Running at 9 with full_tick=1, mid-count: load 5 restarts the period.
  task automatic test_load();
    tick(); tick();
    checks++;
    if (bus.phase !== 4'd9 || bus.full_tick !== 1'b1) begin
      errors++;
      $display("FAIL load pre: got ph=%0d ft=%b want 9 1", bus.phase, bus.full_tick);
    end
    bus.load = 1'b1; bus.ini_phase = 4'd5;
    tick();
    bus.load = 1'b0;
    checks++;
    if (bus.phase !== 4'd5 || bus.full_tick !== 1'b0 || bus.osc_out !== 1'b1) begin
      errors++;
      $display("FAIL load: got ph=%0d ft=%b osc=%b want 5 0 1", bus.phase, bus.full_tick, bus.osc_out);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (bus.phase !== ((k == 4) ? 4'd6 : 4'd5)) begin
        errors++;
        $display("FAIL load step[%0d]: got ph=%0d want %0d", k, bus.phase, (k == 4) ? 6 : 5);
      end
    end
  endtask

  // Advance handshake at div=0, held req, then drop and re-raise.
  task automatic test_shift_adv();
    logic [3:0] exp_ph [8];
    logic       exp_ak [8];
    logic       req_v  [8];
    exp_ph = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12};
    exp_ak = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0};
    req_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,  1'b0};
    bus.div = 8'd0; bus.load = 1'b1; bus.ini_phase = 4'd2;
    tick();
    bus.load = 1'b0; bus.shift_dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.shift_req = req_v[i];
      tick();
      checks++;
      if (bus.phase !== exp_ph[i] || bus.shift_ack !== exp_ak[i]) begin
        errors++;
        $display("FAIL shift_adv[%0d]: got ph=%0d ack=%b want ph=%0d ack=%b",
                 i, bus.phase, bus.shift_ack, exp_ph[i], exp_ak[i]);
      end
    end
  endtask

  // Retard at 15 (no wrap), then advances 14->0 and 15->1 (wraps).
  task automatic test_wrap_shift();
    logic [3:0] ini_v [3];
    logic       dir_v [3];
    logic [3:0] exp_sh [3];
    logic       exp_wp [3];
    logic       exp_ft [3];
    ini_v  = '{4'd14, 4'd13, 4'd14};
    dir_v  = '{1'b0,  1'b1,  1'b1};
    exp_sh = '{4'd15, 4'd0,  4'd1};
    exp_wp = '{1'b0,  1'b1,  1'b1};
    exp_ft = '{1'b0,  1'b1,  1'b1};
    for (int c = 0; c < 3; c++) begin
      bus.load = 1'b1; bus.ini_phase = ini_v[c];
      tick();
      bus.load = 1'b0; bus.shift_req = 1'b1; bus.shift_dir = dir_v[c];
      tick();                       // IDLE -> PEND, normal +1 step
      tick();                       // shift applied
      checks++;
      if (bus.phase !== exp_sh[c] || bus.shift_ack !== 1'b1 ||
          bus.wrap_pulse !== exp_wp[c] || bus.full_tick !== exp_ft[c]) begin
        errors++;
        $display("FAIL wrap_shift[%0d]: got ph=%0d ack=%b wp=%b ft=%b want ph=%0d ack=1 wp=%b ft=%b",
                 c, bus.phase, bus.shift_ack, bus.wrap_pulse, bus.full_tick,
                 exp_sh[c], exp_wp[c], exp_ft[c]);
      end
      bus.shift_req = 1'b0;
      tick();
      checks++;
      if (bus.phase !== exp_sh[c] + 4'd1 || bus.shift_ack !== 1'b0 ||
          bus.wrap_pulse !== (c == 0) || bus.full_tick !== 1'b1) begin
        errors++;
        $display("FAIL wrap_next[%0d]: got ph=%0d ack=%b wp=%b ft=%b want ph=%0d ack=0 wp=%b ft=1",
                 c, bus.phase, bus.shift_ack, bus.wrap_pulse, bus.full_tick,
                 exp_sh[c] + 4'd1, c == 0);
      end
    end
  endtask

  // en=0 holds a pending shift; async reset mid-cycle clears everything.
  task automatic test_async_reset();
    bus.div = 8'd5; bus.load = 1'b1; bus.ini_phase = 4'd12;
    tick();
    bus.load = 1'b0; bus.shift_req = 1'b1; bus.shift_dir = 1'b1;
    tick();                         // PEND, no step yet
    bus.en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (bus.phase !== 4'd12 || bus.shift_ack !== 1'b0 || bus.osc_out !== 1'b0) begin
      errors++;
      $display("FAIL en_hold: got ph=%0d ack=%b osc=%b want 12 0 0", bus.phase, bus.shift_ack, bus.osc_out);
    end
    @(negedge clk);
    re = 1'b1;
    #1;
    checks++;
    if (bus.phase !== 4'd0 || bus.osc_out !== 1'b1 || bus.full_tick !== 1'b0 ||
        bus.shift_ack !== 1'b0 || bus.wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got ph=%0d osc=%b ft=%b ack=%b wp=%b want 0 1 0 0 0",
               bus.phase, bus.osc_out, bus.full_tick, bus.shift_ack, bus.wrap_pulse);
    end
    bus.shift_req = 1'b0; bus.en = 1'b1;
    @(negedge clk);
    re = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (bus.shift_ack !== 1'b0 || bus.phase !== 4'(i / 6)) begin
        errors++;
        $display("FAIL post_reset[%0d]: got ack=%b ph=%0d want ack=0 ph=%0d",
                 i, bus.shift_ack, bus.phase, i / 6);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_prescale();
    test_load();
    test_shift_adv();
    test_wrap_shift();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
